// File: rtl/wbuf_pkg.sv
// Shared types for the weight/window buffer: command opcodes and FSM states.
package wbuf_pkg;

    typedef enum logic [2:0] {
        OP_NOP      = 3'b000,
        OP_LOAD_A   = 3'b001,
        OP_LOAD_B   = 3'b010,
        OP_LOAD_AB  = 3'b011,
        OP_SHIFT    = 3'b100,
        OP_FILL     = 3'b101,
        OP_CLEAR    = 3'b110,
        OP_SHIFT_LD = 3'b111
    } wbuf_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } wbuf_state_e;

endpackage

// File: rtl/wbuf_bank.sv
// One buffer bank: DEPTH entries of WIDTH bits with a valid bit per entry.
// Priority when several controls are raised: clear, then shift, then load.
module wbuf_bank #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     load,
    input  logic [IW-1:0]            load_idx,
    input  logic [WIDTH-1:0]         load_data,
    input  logic                     shift,
    input  logic [WIDTH-1:0]         tail_in,
    input  logic                     tail_vld,
    input  logic                     clear,
    output logic [DEPTH*WIDTH-1:0]   w,
    output logic [DEPTH-1:0]         valid
);

    logic [WIDTH-1:0] ent [DEPTH];
    logic [DEPTH-1:0] vld;

    // Entry and valid storage; shift moves entry i+1 into entry i and feeds the tail.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
            vld <= '0;
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
            vld <= '0;
        end else if (shift) begin
            for (int i = 0; i < DEPTH - 1; i++) ent[i] <= ent[i+1];
            ent[DEPTH-1] <= tail_in;
            vld          <= {tail_vld, vld[DEPTH-1:1]};
        end else if (load) begin
            ent[load_idx] <= load_data;
            vld[load_idx] <= 1'b1;
        end
    end

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_pack
            assign w[g*WIDTH +: WIDTH] = ent[g];
        end
    endgenerate

    assign valid = vld;

endmodule

// File: rtl/wbuf_window.sv
// Weight/window buffer top: opcode decode, auto-fill FSM and error/done pulses
// around two wbuf_bank instances (A from SRAM data, B from SDRAM data_read).
// Optional feature macro: WBUF_SHIFT_LOAD_EN enables opcode 111 (shift with tail load);
// without it opcode 111 is rejected with op_err.
// Handshake: in FILL, a beat is consumed on every rising edge where in_valid is high;
// there is no backpressure, and commands are sampled only when enable_CU is high.
module wbuf_window
    import wbuf_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     enable_CU,
    input  logic [2:0]               mode,
    input  logic [$clog2(DEPTH)-1:0] sel_idx,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         data,
    input  logic [WIDTH-1:0]         data_read,
    output logic [DEPTH*WIDTH-1:0]   w_a,
    output logic [DEPTH*WIDTH-1:0]   w_b,
    output logic [DEPTH-1:0]         valid_a,
    output logic [DEPTH-1:0]         valid_b,
    output logic                     window_ready,
    output logic                     busy,
    output logic                     fill_done,
    output logic                     op_err,
    output wbuf_state_e              state_dbg
);

    localparam int IW = $clog2(DEPTH);

    wbuf_state_e   state, state_n;
    logic [IW-1:0] fill_cnt, fill_cnt_n;
    logic          done_n, err_n;
    logic          load_a, load_b, shift, clear, tail_vld;
    logic [IW-1:0] idx;
    logic [WIDTH-1:0] tail_a, tail_b;
    logic          idx_ok;

    // Non-power-of-2 depths leave index codes that name no entry.
    assign idx_ok = ({1'b0, sel_idx} < (IW+1)'(DEPTH));

    // State, fill counter and pulse registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            fill_cnt  <= '0;
            fill_done <= 1'b0;
            op_err    <= 1'b0;
        end else begin
            state     <= state_n;
            fill_cnt  <= fill_cnt_n;
            fill_done <= done_n;
            op_err    <= err_n;
        end
    end

    // Command decode and fill sequencing; drives the bank controls.
    always_comb begin
        state_n    = state;
        fill_cnt_n = fill_cnt;
        done_n     = 1'b0;
        err_n      = 1'b0;
        load_a     = 1'b0;
        load_b     = 1'b0;
        shift      = 1'b0;
        clear      = 1'b0;
        tail_vld   = 1'b0;
        tail_a     = '0;
        tail_b     = '0;
        idx        = sel_idx;
        case (state)
            IDLE: begin
                if (enable_CU) begin
                    case (wbuf_op_e'(mode))
                        OP_NOP: ;
                        OP_LOAD_A: begin
                            load_a = idx_ok;
                            err_n  = !idx_ok;
                        end
                        OP_LOAD_B: begin
                            load_b = idx_ok;
                            err_n  = !idx_ok;
                        end
                        OP_LOAD_AB: begin
                            load_a = idx_ok;
                            load_b = idx_ok;
                            err_n  = !idx_ok;
                        end
                        OP_SHIFT: shift = 1'b1;
                        OP_FILL: begin
                            state_n    = FILL;
                            fill_cnt_n = '0;
                        end
                        OP_CLEAR: clear = 1'b1;
                        OP_SHIFT_LD: begin
`ifdef WBUF_SHIFT_LOAD_EN
                            shift    = 1'b1;
                            tail_a   = data;
                            tail_b   = data_read;
                            tail_vld = 1'b1;
`else
                            err_n    = 1'b1;
`endif
                        end
                        default: err_n = 1'b1;
                    endcase
                end
            end
            FILL: begin
                if (enable_CU && wbuf_op_e'(mode) == OP_CLEAR) begin
                    clear   = 1'b1;
                    state_n = IDLE;
                end else begin
                    err_n = enable_CU && (wbuf_op_e'(mode) != OP_NOP);
                    idx   = fill_cnt;
                    if (in_valid) begin
                        load_a = 1'b1;
                        load_b = 1'b1;
                        if (fill_cnt == IW'(DEPTH - 1)) begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                        end else begin
                            fill_cnt_n = fill_cnt + IW'(1);
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    wbuf_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IW(IW)) u_bank_a (
        .clk       (clk),
        .nrst      (nrst),
        .load      (load_a),
        .load_idx  (idx),
        .load_data (data),
        .shift     (shift),
        .tail_in   (tail_a),
        .tail_vld  (tail_vld),
        .clear     (clear),
        .w         (w_a),
        .valid     (valid_a)
    );

    wbuf_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IW(IW)) u_bank_b (
        .clk       (clk),
        .nrst      (nrst),
        .load      (load_b),
        .load_idx  (idx),
        .load_data (data_read),
        .shift     (shift),
        .tail_in   (tail_b),
        .tail_vld  (tail_vld),
        .clear     (clear),
        .w         (w_b),
        .valid     (valid_b)
    );

    assign window_ready = (&valid_a) & (&valid_b);
    assign busy         = (state == FILL);
    assign state_dbg    = state;

endmodule

// File: tb/tb_wbuf_window.sv
// Bench for wbuf_window: directed scenarios followed by random commands, all
// checked cycle by cycle against an array-based model of the buffer contents.
module tb_wbuf_window;
  import wbuf_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int IW    = $clog2(DEPTH);
  localparam int DW    = DEPTH * WIDTH;
  localparam int EW    = 2 * DW + 2 * DEPTH + 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  logic             enable_cu = 1'b0;
  logic [2:0]       mode = 3'd0;
  logic [IW-1:0]    sel_idx = '0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] data = '0;
  logic [WIDTH-1:0] data_read = '0;
  logic [DW-1:0]    w_a, w_b;
  logic [DEPTH-1:0] valid_a, valid_b;
  logic             window_ready, busy, fill_done, op_err;
  wbuf_state_e      state_dbg;

  wbuf_window #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .enable_CU    (enable_cu),
    .mode         (mode),
    .sel_idx      (sel_idx),
    .in_valid     (in_valid),
    .data         (data),
    .data_read    (data_read),
    .w_a          (w_a),
    .w_b          (w_b),
    .valid_a      (valid_a),
    .valid_b      (valid_b),
    .window_ready (window_ready),
    .busy         (busy),
    .fill_done    (fill_done),
    .op_err       (op_err),
    .state_dbg    (state_dbg)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [WIDTH-1:0] ma [DEPTH];
  logic [WIDTH-1:0] mb [DEPTH];
  bit               va [DEPTH];
  bit               vb [DEPTH];
  bit               m_fill;
  int               m_cnt;
  bit               m_done, m_err;

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      ma[i] = '0; mb[i] = '0; va[i] = 0; vb[i] = 0;
    end
    m_fill = 0; m_cnt = 0; m_done = 0; m_err = 0;
  endfunction

  function automatic void model_shift(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_, input bit tv);
    for (int i = 0; i < DEPTH - 1; i++) begin
      ma[i] = ma[i+1]; mb[i] = mb[i+1]; va[i] = va[i+1]; vb[i] = vb[i+1];
    end
    ma[DEPTH-1] = ta; mb[DEPTH-1] = tb_; va[DEPTH-1] = tv; vb[DEPTH-1] = tv;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      ma[i] = '0; mb[i] = '0; va[i] = 0; vb[i] = 0;
    end
  endfunction

  function automatic void model_step(input bit en, input int md, input int idx, input bit inv,
                                     input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] dr);
    m_done = 0; m_err = 0;
    if (!m_fill) begin
      if (en) begin
        if (md >= 1 && md <= 3) begin
          if (idx >= DEPTH) m_err = 1;
          else begin
            if (md != 2) begin ma[idx] = d;  va[idx] = 1; end
            if (md != 1) begin mb[idx] = dr; vb[idx] = 1; end
          end
        end else if (md == 4) model_shift('0, '0, 0);
        else if (md == 5) begin m_fill = 1; m_cnt = 0; end
        else if (md == 6) model_clear();
        else if (md == 7) begin
`ifdef WBUF_SHIFT_LOAD_EN
          model_shift(d, dr, 1);
`else
          m_err = 1;
`endif
        end
      end
    end else begin
      if (en && md == 6) begin
        model_clear(); m_fill = 0;
      end else begin
        if (en && md != 0) m_err = 1;
        if (inv) begin
          ma[m_cnt] = d; mb[m_cnt] = dr; va[m_cnt] = 1; vb[m_cnt] = 1;
          m_cnt++;
          if (m_cnt == DEPTH) begin m_fill = 0; m_done = 1; end
        end
      end
    end
  endfunction

  function automatic logic [EW-1:0] model_snapshot();
    logic [DW-1:0]    pa, pb;
    logic [DEPTH-1:0] qa, qb;
    bit               all;
    all = 1;
    for (int i = 0; i < DEPTH; i++) begin
      pa[i*WIDTH +: WIDTH] = ma[i];
      pb[i*WIDTH +: WIDTH] = mb[i];
      qa[i] = va[i]; qb[i] = vb[i];
      if (!va[i] || !vb[i]) all = 0;
    end
    return {pa, pb, qa, qb, all, m_fill, m_done, m_err, m_fill};
  endfunction

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];

  // Monitor: compares DUT outputs with the oldest expectation one step after each edge.
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("w_a",          64'(w_a),          64'(e[EW-1 -: DW]));
        chk("w_b",          64'(w_b),          64'(e[EW-DW-1 -: DW]));
        chk("valid_a",      64'(valid_a),      64'(e[2*DEPTH+4 -: DEPTH]));
        chk("valid_b",      64'(valid_b),      64'(e[DEPTH+4 -: DEPTH]));
        chk("window_ready", 64'(window_ready), 64'(e[4]));
        chk("busy",         64'(busy),         64'(e[3]));
        chk("fill_done",    64'(fill_done),    64'(e[2]));
        chk("op_err",       64'(op_err),       64'(e[1]));
        chk("state_dbg",    64'(state_dbg == FILL), 64'(e[0]));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic cyc(input bit en, input int md, input int idx, input bit inv,
                     input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] dr);
    @(negedge clk);
    enable_cu = en; mode = 3'(md); sel_idx = IW'(idx); in_valid = inv;
    data = d; data_read = dr;
    @(posedge clk);
    model_step(en, md, idx, inv, d, dr);
    exp_q.push_back(model_snapshot());
    #2;
  endtask

  task automatic idle_cyc();
    cyc(0, 0, 0, 0, '0, '0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_w_a"}, 64'(w_a), 64'd0);
    chk({tag, "_w_b"}, 64'(w_b), 64'd0);
    chk({tag, "_valid"}, 64'({valid_a, valid_b}), 64'd0);
    chk({tag, "_flags"}, 64'({window_ready, busy, fill_done, op_err}), 64'd0);
  endtask

  initial begin
    logic [7:0] d1;
    model_reset();
    #12;
    check_all_zero("reset");
    chk("reset_state", 64'(state_dbg == IDLE), 64'd1);
    @(negedge clk);
    nrst = 1'b1;

    // 1: load bank A only
    for (int i = 0; i < DEPTH; i++) cyc(1, 1, i, 0, 8'((i + 1) * 8'h11), 8'h00);
    chk("t1_w_a", 64'(w_a), 64'h44332211);
    chk("t1_valid_a", 64'(valid_a), 64'hF);
    chk("t1_ready", 64'(window_ready), 64'd0);

    // 2: gapped auto-fill
    cyc(1, 5, 0, 0, '0, '0);
    chk("t2_busy0", 64'(busy), 64'd1);
    for (int i = 0, b = 0; i < 5; i++) begin
      bit v;
      v = (i != 1);
      cyc(0, 0, 0, v, 8'(b + 1), 8'(b + 5));
      if (v) b++;
      if (i < 4) chk("t2_busy", 64'(busy), 64'd1);
    end
    chk("t2_done", 64'(fill_done), 64'd1);
    chk("t2_ready", 64'(window_ready), 64'd1);
    chk("t2_w_b", 64'(w_b), 64'h08070605);
    idle_cyc();
    chk("t2_done_pulse", 64'(fill_done), 64'd0);

    // 3: shift a full window
    for (int i = 0; i < DEPTH; i++) cyc(1, 1, i, 0, 8'((i + 1) * 8'h11), 8'h00);
    cyc(1, 4, 0, 0, '0, '0);
    chk("t3_w_a", 64'(w_a), 64'h00443322);
    chk("t3_valid_a", 64'(valid_a), 64'h7);
    chk("t3_ready", 64'(window_ready), 64'd0);

    // 4: illegal command in FILL, then abort with CLEAR
    cyc(1, 5, 0, 0, '0, '0);
    cyc(1, 1, 0, 0, 8'h99, 8'h00);
    chk("t4_err", 64'(op_err), 64'd1);
    chk("t4_nowrite", 64'(w_a[7:0]), 64'h22);
    cyc(1, 6, 0, 0, '0, '0);
    check_all_zero("t4_clear");
    idle_cyc();
    chk("t4_no_done", 64'(fill_done), 64'd0);

    // 5: opcode 111 on a full window
    for (int i = 0; i < DEPTH; i++) cyc(1, 3, i, 0, 8'((i + 1) * 8'h11), 8'h5A);
    cyc(1, 7, 0, 0, 8'hAA, 8'hBB);
`ifdef WBUF_SHIFT_LOAD_EN
    chk("t5_w_a", 64'(w_a), 64'hAA443322);
    chk("t5_valid_a", 64'(valid_a), 64'hF);
`else
    chk("t5_w_a", 64'(w_a), 64'h44332211);
    chk("t5_err", 64'(op_err), 64'd1);
`endif

    // 6: asynchronous reset in the middle of a fill
    cyc(1, 5, 0, 0, '0, '0);
    cyc(0, 0, 0, 1, 8'h31, 8'h41);
    cyc(0, 0, 0, 1, 8'h32, 8'h42);
    #2;
    nrst = 1'b0;
    model_reset();
    #1;
    check_all_zero("t6_async");
    chk("t6_state", 64'(state_dbg == IDLE), 64'd1);
    @(negedge clk);
    nrst = 1'b1;
    idle_cyc();

    // random commands
    for (int n = 0; n < 400; n++) begin
      bit en;
      int md;
      en = ($urandom_range(0, 3) != 0);
      md = $urandom_range(0, 7);
      if ($urandom_range(0, 7) == 0) md = 5;
      d1 = 8'($urandom);
      cyc(en, md, $urandom_range(0, DEPTH - 1), 1'($urandom_range(0, 1)), d1, 8'($urandom));
    end

    // drain with a bounded wait
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
